load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, meaning the data memory size in bytes; any byte address >= MEM_BYTES is out of range.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, execute stage presents a request.
REQ-005 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_signed, input, 1, loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-011 SHALL have port req_rd, input, 5, load destination register.
REQ-012 SHALL have port mem_address, output, 32, word-aligned address to data memory.
REQ-013 SHALL have port mem_writeData, output, 32, word written to data memory.
REQ-014 SHALL have port mem_memWrite, output, 1; memory commits the word on the rising clock edge while this is high.
REQ-015 SHALL have port mem_memRead, output, 1; mem_readData is valid combinationally in the same cycle.
REQ-016 SHALL have port mem_readData, input, 32, word read from data memory.
REQ-017 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the response handshake to writeback.
REQ-018 SHALL have ports rsp_data (output, 32), rsp_rd (output, 5), rsp_write_reg (output, 1) and rsp_fault (output, 1).
REQ-019 SHALL have port access_count, output, 16, count of completed non-faulting accesses.

Function
REQ-020 SHALL use FSM states IDLE, READ, WRITE and RESP; req_ready = 1 only in IDLE.
REQ-021 SHALL latch all req_* fields on the rising edge where req_valid && req_ready.
REQ-022 SHALL fault on any of: size = 11; half with addr[0] != 0; word with addr[1:0] != 0; addr >= MEM_BYTES.
REQ-023 SHALL, on a faulting request, go IDLE->RESP with no memRead or memWrite pulse; rsp_fault = 1, rsp_data = 0, rsp_write_reg = 0.
REQ-024 SHALL run loads as IDLE->READ->RESP; in READ, mem_memRead = 1 and mem_address = {addr[31:2], 2'b00}.
REQ-025 SHALL capture mem_readData into rsp_data at the end of READ.
REQ-026 SHALL extract loaded bytes little-endian, byte k = bits [8k+7:8k], lane selected by addr[1:0], then sign- or zero-extend to 32 bits.
REQ-027 SHALL run word stores as IDLE->WRITE->RESP; in WRITE, mem_memWrite = 1 for exactly one cycle and mem_writeData = req_wdata.
REQ-028 SHALL run byte and half stores as read-modify-write, IDLE->READ->WRITE->RESP.
REQ-029 SHALL, for read-modify-write, replace only the addressed lanes with the low byte/half of wdata and keep the other lanes from the READ data.
REQ-030 SHALL have these latencies from the accept edge N: rsp_valid from N+1 (fault), N+2 (load, word store), N+3 (sub-word store).
REQ-031 SHALL, in RESP, hold rsp_valid and all rsp_* stable until rsp_ready; advance RESP->IDLE on the edge where rsp_ready = 1.
REQ-032 SHALL accept no new request in the same cycle as the RESP->IDLE transition.
REQ-033 SHALL set rsp_write_reg = 1 only for a non-faulting load with rd != 0.
REQ-034 SHALL set rsp_data = 0 for stores; rsp_rd = latched rd in all cases.
REQ-035 SHALL hold mem_* outputs at 0 outside READ/WRITE; mem_memRead and mem_memWrite are never both high.
REQ-036 SHALL increment access_count by 1 at RESP->IDLE for a non-faulting access, saturating at 0xFFFF.
REQ-037 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-038 SHALL, while reset is high, immediately force state = IDLE, req_ready = 1, and all other outputs, including access_count, to 0.
REQ-039 SHALL, on reset during READ, WRITE or RESP, abort the operation with mem_memWrite low immediately; a write already committed at an earlier edge is not rolled back.

Verification
REQ-040 SHALL verify: word store 0xDEADBEEF @0x10, then word load @0x10 -> rsp_data 0xDEADBEEF, rsp_write_reg 1, rsp_valid at N+2, access_count 2.
REQ-041 SHALL verify: byte store 0xAB @0x11 over 0xDEADBEEF -> memory word 0xDEADABEF, rsp at N+3; signed byte load @0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-042 SHALL verify: half load @0x13 and word load @0x80 -> rsp_fault 1 at N+1, no mem strobes, access_count unchanged.
REQ-043 SHALL verify: rsp_ready held low 3 cycles -> rsp_* stable, req_ready 0, and a pending req_valid is not accepted.
REQ-044 SHALL verify: reset asserted mid-WRITE -> mem_memWrite 0 the same cycle, all outputs at reset values, and the next request completes normally.
REQ-045 SHALL verify: load with rd = 0 -> rsp_write_reg 0, rsp_data still holds the loaded value.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Moves execute-stage load/store requests to a word-wide data memory and
//   returns one response per request to writeback.
//
//   Ports
//     clock, reset            rising-edge clock, asynchronous active-high reset
//     req_*                   request from execute (valid/ready)
//     mem_*                   word-wide data memory; read data is combinational,
//                             a write commits on the rising edge while mem_memWrite
//     rsp_*                   response to writeback (valid/ready)
//     access_count            completed non-faulting accesses, saturating
//     fsm_state               current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   req_ready is high only in IDLE. rsp_valid is high only in RESP, and every
//   rsp_* field holds steady until the edge where rsp_ready is seen; that edge
//   returns the unit to IDLE, so no request is taken on the same edge.
//
//   Byte and half stores are read-modify-write: READ fetches the word, the
//   addressed lanes are merged in, and WRITE stores the merged word.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_memWrite,
   output logic        mem_memRead,
   input  logic [31:0] mem_readData,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        rsp_write_reg,
   output logic        rsp_fault,
   output logic [15:0] access_count,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic        wr_q;
   logic [1:0]  size_q;
   logic        sgn_q;
   logic [31:0] addr_q;
   logic [31:0] wword_q;   // store data; becomes the merged word after READ
   logic [4:0]  rd_q;
   logic        fault_q;
   logic [31:0] data_q;
   logic [15:0] count_q;

   logic        accept;
   logic        req_fault;
   logic [4:0]  shift;
   logic [31:0] rd_shifted;
   logic [31:0] load_val;
   logic [31:0] lane_mask;
   logic [31:0] lane_ins;
   logic [31:0] merged;

   assign accept = req_valid && (state == IDLE);

   // Misaligned, illegal-size and out-of-range requests never touch memory.
   always_comb begin
      req_fault = 1'b0;
      case (req_size)
         2'b01:   if (req_addr[0])          req_fault = 1'b1;
         2'b10:   if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
         2'b11:   req_fault = 1'b1;
         default: req_fault = 1'b0;
      endcase
      if (req_addr >= 32'(MEM_BYTES)) req_fault = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_fault)                          state_nxt = RESP;
               else if (req_write && req_size == 2'b10) state_nxt = WRITE;
               else                                    state_nxt = READ;
            end
         end
         READ:    state_nxt = wr_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Little-endian lane select for loads and lane merge for sub-word stores.
   always_comb begin
      shift      = {addr_q[1:0], 3'b000};
      rd_shifted = mem_readData >> shift;
      case (size_q)
         2'b00:   load_val = sgn_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                   : {24'd0, rd_shifted[7:0]};
         2'b01:   load_val = sgn_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                   : {16'd0, rd_shifted[15:0]};
         default: load_val = mem_readData;
      endcase
      if (size_q == 2'b00) begin
         lane_mask = 32'h0000_00FF << shift;
         lane_ins  = {24'd0, wword_q[7:0]} << shift;
      end else begin
         lane_mask = 32'h0000_FFFF << shift;
         lane_ins  = {16'd0, wword_q[15:0]} << shift;
      end
      merged = (mem_readData & ~lane_mask) | lane_ins;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         addr_q  <= 32'd0;
         wword_q <= 32'd0;
         rd_q    <= 5'd0;
         fault_q <= 1'b0;
         data_q  <= 32'd0;
         count_q <= 16'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wword_q <= req_wdata;
            rd_q    <= req_rd;
            fault_q <= req_fault;
            data_q  <= 32'd0;
         end
         if (state == READ) begin
            if (wr_q) wword_q <= merged;
            else      data_q  <= load_val;
         end
         if (state == RESP && rsp_ready && !fault_q && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
      end
   end

   assign req_ready     = (state == IDLE);
   assign mem_memRead   = (state == READ);
   assign mem_memWrite  = (state == WRITE);
   assign mem_address   = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_writeData = (state == WRITE) ? wword_q : 32'd0;
   assign rsp_valid     = (state == RESP);
   assign rsp_data      = (state == RESP) ? data_q : 32'd0;
   assign rsp_rd        = (state == RESP) ? rd_q : 5'd0;
   assign rsp_fault     = (state == RESP) && fault_q;
   assign rsp_write_reg = (state == RESP) && !fault_q && !wr_q && (rd_q != 5'd0);
   assign access_count  = count_q;
   assign fsm_state     = state;

endmodule
